// File: rtl/quota_bitstream_gen.sv
// quota_bitstream_gen
// Serialises one BITSTREAM-bit stochastic stream per accepted quota. Each
// stream carries exactly `quota` ones. The ones are spread either as a
// thermometer (ones first, MODE=0) or by comparing the quota against the
// bit-reversed beat index (low-discrepancy, MODE=1).
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   in_valid  in   quota present on in_quota
//   in_quota  in   [QW] number of ones for the next stream
//   in_ready  out  quota can be accepted this cycle
//   out_valid out  out_bit is valid
//   out_bit   out  current stream bit
//   out_last  out  marks the final bit of the stream
//   out_ready in   consumer takes the bit this cycle
//   busy      out  a stream is in progress
module quota_bitstream_gen #(
  parameter  int BITSTREAM = 64,
  parameter  int MODE      = 1,
  localparam int QW        = $clog2(BITSTREAM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [QW-1:0] in_quota,
  output logic          in_ready,
  output logic          out_valid,
  output logic          out_bit,
  output logic          out_last,
  input  logic          out_ready,
  output logic          busy
);

  if (BITSTREAM < 2 || (BITSTREAM & (BITSTREAM - 1)) != 0) begin : g_bad_len
    $error("quota_bitstream_gen: BITSTREAM must be a power of two >= 2");
  end

  typedef enum logic {IDLE, STREAM} state_t;

  state_t        state, state_next;
  logic [QW-1:0] cnt, quota_r, seq;
  logic          in_fire, out_fire;

  // State register and stream datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      quota_r <= '0;
    end else begin
      state <= state_next;
      if (in_fire) quota_r <= in_quota;
      // cnt wraps to zero naturally on the final beat, so a back-to-back
      // accept needs no explicit clear; only a load from IDLE does.
      if (state == IDLE && in_fire) cnt <= '0;
      else if (out_fire)            cnt <= cnt + 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (in_fire) state_next = STREAM;
      STREAM: if (out_fire && out_last) state_next = in_fire ? STREAM : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: everything but in_ready comes from registered state only.
  always_comb begin
    seq = cnt;
    if (MODE != 0) begin
      for (int unsigned i = 0; i < QW; i++) seq[i] = cnt[QW-1-i];
    end
    out_valid = (state == STREAM);
    busy      = (state == STREAM);
    out_last  = (state == STREAM) && (cnt == '1);
    out_bit   = (state == STREAM) && (seq < quota_r);
    out_fire  = out_valid && out_ready;
    // Accepting on the final beat lets the next stream follow with no bubble.
    in_ready  = (state == IDLE) || (out_fire && out_last);
    in_fire   = in_valid && in_ready;
  end

endmodule

// File: tb/tb_quota_bitstream_gen.sv
// Testbench for quota_bitstream_gen: drives both MODE=0 and MODE=1 instances
// from shared stimulus and checks every beat against a reference model that
// derives each stream bit directly from its beat index.
module tb_quota_bitstream_gen;
  localparam int BITSTREAM = 64;
  localparam int QW        = 6;
  localparam int MAXCYC    = 4000;

  logic          clk = 1'b0;
  logic          rst, in_valid, out_ready;
  logic [QW-1:0] in_quota;
  logic          in_ready0, out_valid0, out_bit0, out_last0, busy0;
  logic          in_ready1, out_valid1, out_bit1, out_last1, busy1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  quota_bitstream_gen #(.BITSTREAM(BITSTREAM), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_quota(in_quota),
    .in_ready(in_ready0), .out_valid(out_valid0), .out_bit(out_bit0),
    .out_last(out_last0), .out_ready(out_ready), .busy(busy0)
  );

  quota_bitstream_gen #(.BITSTREAM(BITSTREAM), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_quota(in_quota),
    .in_ready(in_ready1), .out_valid(out_valid1), .out_bit(out_bit1),
    .out_last(out_last1), .out_ready(out_ready), .busy(busy1)
  );

  typedef struct {
    int quota;
    int stall_pct;
    int exp_ones;
  } vec_t;

  // Reference bit of beat k: thermometer puts ones at the lowest indices;
  // low-discrepancy mode ranks beats by their index read backwards in binary.
  function automatic int exp_bit(int mode, int q, int k);
    int r = 0;
    int t = k;
    if (mode == 0) return (k < q) ? 1 : 0;
    for (int i = 0; i < QW; i++) begin
      r = r * 2 + t % 2;
      t = t / 2;
    end
    return (r < q) ? 1 : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " out_valid0"}, int'(out_valid0), 0);
    check({tag, " out_valid1"}, int'(out_valid1), 0);
    check({tag, " busy0"},      int'(busy0), 0);
    check({tag, " busy1"},      int'(busy1), 0);
    check({tag, " in_ready0"},  int'(in_ready0), 1);
    check({tag, " in_ready1"},  int'(in_ready1), 1);
    check({tag, " out_bit"},    int'({out_bit1, out_bit0}), 0);
    check({tag, " out_last"},   int'({out_last1, out_last0}), 0);
  endtask

  // From IDLE: offer quota q, confirm acceptance and one-cycle latency.
  task automatic start_stream(input int q);
    in_valid  = 1'b1;
    in_quota  = QW'(q);
    out_ready = 1'($urandom_range(1));
    #1;
    check("accept in_ready0", int'(in_ready0), 1);
    check("accept in_ready1", int'(in_ready1), 1);
    check("pre-accept out_valid", int'({out_valid1, out_valid0}), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Run nbeats accepted beats of a stream with quota q. When chain is set,
  // in_valid stays high with quota nq so it is taken on the final beat.
  task automatic do_beats(input int q, input int nbeats, input int stall_pct,
                          input bit chain, input int nq,
                          output int ones0, output int ones1);
    int k = 0;
    int cyc = 0;
    ones0 = 0;
    ones1 = 0;
    in_valid = chain;
    in_quota = QW'(nq);
    while (k < nbeats && cyc < MAXCYC) begin
      out_ready = ($urandom_range(99) >= stall_pct) ? 1'b1 : 1'b0;
      if (!chain) in_quota = QW'($urandom_range(BITSTREAM - 1));
      #1;
      check("out_valid0", int'(out_valid0), 1);
      check("out_valid1", int'(out_valid1), 1);
      check("busy",       int'({busy1, busy0}), 3);
      check("out_last0",  int'(out_last0), (k == BITSTREAM - 1) ? 1 : 0);
      check("out_last1",  int'(out_last1), (k == BITSTREAM - 1) ? 1 : 0);
      check("out_bit0",   int'(out_bit0), exp_bit(0, q, k));
      check("out_bit1",   int'(out_bit1), exp_bit(1, q, k));
      check("in_ready0",  int'(in_ready0), (out_ready && k == BITSTREAM - 1) ? 1 : 0);
      check("in_ready1",  int'(in_ready1), (out_ready && k == BITSTREAM - 1) ? 1 : 0);
      if (out_ready) begin
        ones0 += int'(out_bit0);
        ones1 += int'(out_bit1);
        k++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (k < nbeats) begin
      fails++;
      tests++;
      $display("FAIL beat timeout: got %0d beats required %0d", k, nbeats);
    end
  endtask

  vec_t vecs[6];
  int   o0, o1, o2, o3;

  initial begin
    vecs[0] = '{quota: 0,  stall_pct: 0,  exp_ones: 0};
    vecs[1] = '{quota: 32, stall_pct: 0,  exp_ones: 32};
    vecs[2] = '{quota: 10, stall_pct: 0,  exp_ones: 10};
    vecs[3] = '{quota: 63, stall_pct: 0,  exp_ones: 63};
    vecs[4] = '{quota: 17, stall_pct: 50, exp_ones: 17};
    vecs[5] = '{quota: 1,  stall_pct: 30, exp_ones: 1};

    rst = 1'b1; in_valid = 1'b0; in_quota = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;

    // Table-driven single streams.
    foreach (vecs[i]) begin
      start_stream(vecs[i].quota);
      do_beats(vecs[i].quota, BITSTREAM, vecs[i].stall_pct, 1'b0, 0, o0, o1);
      check("vec ones mode0", o0, vecs[i].exp_ones);
      check("vec ones mode1", o1, vecs[i].exp_ones);
      check_idle("vec end");
    end

    // Back-to-back: second quota accepted on the final beat of the first.
    start_stream(5);
    do_beats(5, BITSTREAM, 0, 1'b1, 60, o0, o1);
    in_valid = 1'b0;
    #1;
    check("b2b no bubble", int'({out_valid1, out_valid0}), 3);
    do_beats(60, BITSTREAM, 0, 1'b0, 0, o2, o3);
    check("b2b ones first",  o0 + o1, 10);
    check("b2b ones second", o2 + o3, 120);
    check_idle("b2b end");

    // Reset mid-stream abandons the stream; the next one is clean.
    start_stream(40);
    do_beats(40, 20, 0, 1'b0, 0, o0, o1);
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_idle("mid reset");
    rst = 1'b0;
    start_stream(3);
    do_beats(3, BITSTREAM, 0, 1'b0, 0, o0, o1);
    check("post-reset ones0", o0, 3);
    check("post-reset ones1", o1, 3);
    check_idle("post-reset end");

    // Randomized streams, sometimes chained back-to-back.
    begin
      int q = $urandom_range(BITSTREAM - 1);
      start_stream(q);
      for (int s = 0; s < 10; s++) begin
        bit chain = (s < 9) ? 1'($urandom_range(1)) : 1'b0;
        int nq    = $urandom_range(BITSTREAM - 1);
        int stall = $urandom_range(70);
        do_beats(q, BITSTREAM, stall, chain, nq, o0, o1);
        check("rand ones0", o0, q);
        check("rand ones1", o1, q);
        in_valid = 1'b0;
        if (chain) begin
          q = nq;
        end else begin
          check_idle("rand end");
          if (s < 9) begin
            q = $urandom_range(BITSTREAM - 1);
            start_stream(q);
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
